// File: rtl/sdram_cmd_sched_if.sv
// sdram_cmd_sched_if: bundles the host request channel and the four
// command-generator start/done handshakes that surround the scheduler.
// master: the scheduler itself; slave: host plus command generators.
interface sdram_cmd_sched_if #(
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2
);
    // Host request channel
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [BANK_W+ROW_W+COL_W-1:0] req_addr;

    // Latched command fields towards the generators
    logic [BANK_W-1:0]             bank;
    logic [ROW_W-1:0]              row;
    logic [COL_W-1:0]              col;
    logic                          is_write;

    // Generator handshakes
    logic                          act_start;
    logic                          act_done;
    logic                          rw_start;
    logic                          rw_done;
    logic                          pre_start;
    logic                          pre_done;
    logic                          ref_start;
    logic                          ref_done;

    // Status
    logic                          busy;

    modport master (
        input  req_valid, req_write, req_addr,
        input  act_done, rw_done, pre_done, ref_done,
        output req_ready, bank, row, col, is_write,
        output act_start, rw_start, pre_start, ref_start,
        output busy
    );

    modport slave (
        output req_valid, req_write, req_addr,
        output act_done, rw_done, pre_done, ref_done,
        input  req_ready, bank, row, col, is_write,
        input  act_start, rw_start, pre_start, ref_start,
        input  busy
    );
endinterface

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: top-level SDRAM command scheduler.
// Accepts host read/write requests, latches the {bank,row,col} address and
// walks the active / read-write / precharge generators through one-cycle
// start pulses and one-cycle done pulses. Owns the periodic refresh timer;
// a pending refresh takes priority over new requests but never interrupts
// a sequence already in flight.
// Build option: define OPEN_ROW_EN for the open-page policy (rows are left
// open after the access; page hits skip ACT, misses precharge first). With
// the macro undefined every access is closed with a precharge.
module sdram_cmd_sched #(
    parameter int ROW_W        = 13,
    parameter int COL_W        = 9,
    parameter int BANK_W       = 2,
    parameter int REF_INTERVAL = 780,
    parameter int REF_CNT_W    = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    sdram_cmd_sched_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ACT   = 4'd1,
        S_ACT_W = 4'd2,
        S_RW    = 4'd3,
        S_RW_W  = 4'd4,
        S_PRE   = 4'd5,
        S_PRE_W = 4'd6,
        S_REF   = 4'd7,
        S_REF_W = 4'd8
    } state_t;

    state_t                state_q;
    state_t                state_d;

    // Request address split into its fields
    logic [BANK_W-1:0]     req_bank;
    logic [ROW_W-1:0]      req_row;
    logic [COL_W-1:0]      req_col;

    // Latched command fields
    logic [BANK_W-1:0]     bank_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic                  is_write_q;

    // Refresh timer
    logic [REF_CNT_W-1:0]  ref_cnt_q;
    logic                  ref_wrap;
    logic                  ref_pending_q;

    // Decoded controls and outputs
    logic                  accept;
    logic                  req_ready;
    logic                  act_start;
    logic                  rw_start;
    logic                  pre_start;
    logic                  ref_start;
    logic                  busy;

    assign req_col  = bus.req_addr[COL_W-1:0];
    assign req_row  = bus.req_addr[COL_W +: ROW_W];
    assign req_bank = bus.req_addr[COL_W+ROW_W +: BANK_W];

    assign ref_wrap = (ref_cnt_q == REF_CNT_W'(REF_INTERVAL - 1));

`ifdef OPEN_ROW_EN
    // Open-page bookkeeping: which row (if any) is currently left open,
    // and whether the precharge in progress is clearing the way for an ACT
    // (page miss) rather than for a refresh.
    logic                  open_valid_q;
    logic [BANK_W-1:0]     open_bank_q;
    logic [ROW_W-1:0]      open_row_q;
    logic                  act_after_pre_q;
    logic                  act_after_pre_d;
    logic                  page_hit;

    assign page_hit = open_valid_q
                   && (req_bank == open_bank_q)
                   && (req_row  == open_row_q);
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; outputs depend on registered state only
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        // Ready is forced low while reset is held, independent of state
        req_ready = n_rst && (state_q == S_IDLE) && !ref_pending_q;
        act_start = (state_q == S_ACT);
        rw_start  = (state_q == S_RW);
        pre_start = (state_q == S_PRE);
        ref_start = (state_q == S_REF);
        busy      = (state_q != S_IDLE);
`ifdef OPEN_ROW_EN
        act_after_pre_d = act_after_pre_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
`ifdef OPEN_ROW_EN
                    // An open row must be closed before refreshing
                    act_after_pre_d = 1'b0;
                    state_d         = open_valid_q ? S_PRE : S_REF;
`else
                    state_d = S_REF;
`endif
                end else if (bus.req_valid) begin
                    accept = 1'b1;
`ifdef OPEN_ROW_EN
                    if (!open_valid_q) begin
                        state_d = S_ACT;
                    end else if (page_hit) begin
                        state_d = S_RW;
                    end else begin
                        act_after_pre_d = 1'b1;
                        state_d         = S_PRE;
                    end
`else
                    state_d = S_ACT;
`endif
                end
            end
            S_ACT:   state_d = S_ACT_W;
            S_ACT_W: if (bus.act_done) state_d = S_RW;
            S_RW:    state_d = S_RW_W;
            S_RW_W: begin
                if (bus.rw_done) begin
`ifdef OPEN_ROW_EN
                    state_d = S_IDLE;
`else
                    state_d = S_PRE;
`endif
                end
            end
            S_PRE:   state_d = S_PRE_W;
            S_PRE_W: begin
                if (bus.pre_done) begin
`ifdef OPEN_ROW_EN
                    if (act_after_pre_q) begin
                        state_d = S_ACT;
                    end else if (ref_pending_q) begin
                        state_d = S_REF;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_REF:   state_d = S_REF_W;
            S_REF_W: if (bus.ref_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request fields on the accepting edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            is_write_q <= 1'b0;
        end else if (accept) begin
            bank_q     <= req_bank;
            row_q      <= req_row;
            col_q      <= req_col;
            is_write_q <= bus.req_write;
        end
    end

    // Free-running refresh interval counter and the single pending flag;
    // a new interval elapsing wins over the clear so no refresh is lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
        end else begin
            if (ref_wrap) begin
                ref_cnt_q <= '0;
            end else begin
                ref_cnt_q <= ref_cnt_q + REF_CNT_W'(1);
            end

            if (ref_wrap) begin
                ref_pending_q <= 1'b1;
            end else if (state_q == S_REF) begin
                ref_pending_q <= 1'b0;
            end
        end
    end

`ifdef OPEN_ROW_EN
    // Remember why the current precharge was issued
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            act_after_pre_q <= 1'b0;
        end else begin
            act_after_pre_q <= act_after_pre_d;
        end
    end

    // Track the row left open after each access; a precharge closes it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            open_valid_q <= 1'b0;
            open_bank_q  <= '0;
            open_row_q   <= '0;
        end else if ((state_q == S_RW_W) && bus.rw_done) begin
            open_valid_q <= 1'b1;
            open_bank_q  <= bank_q;
            open_row_q   <= row_q;
        end else if ((state_q == S_PRE_W) && bus.pre_done) begin
            open_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.req_ready = req_ready;
    assign bus.bank      = bank_q;
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.is_write  = is_write_q;
    assign bus.act_start = act_start;
    assign bus.rw_start  = rw_start;
    assign bus.pre_start = pre_start;
    assign bus.ref_start = ref_start;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// tb_sdram_cmd_sched: directed bench for the SDRAM command scheduler.
// Generator responders answer each start with a done pulse resp_dly cycles
// later; every start pulse is logged as "<tag><cycle> " where cycle counts
// rising edges since reset release (A=act, W=rw, P=pre, R=ref).
`timescale 1ns/1ps
module tb_sdram_cmd_sched;
    localparam int ROW_W        = 13;
    localparam int COL_W        = 9;
    localparam int BANK_W       = 2;
    localparam int REF_INTERVAL = 20;
    localparam int REF_CNT_W    = 16;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sdram_cmd_sched_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W)) bus();

    sdram_cmd_sched #(
        .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W),
        .REF_INTERVAL(REF_INTERVAL), .REF_CNT_W(REF_CNT_W)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;
    int         resp_dly = 1;
    string      ev_log;
    string      tags [4] = '{"A", "W", "P", "R"};
    logic [3:0] done_m = 4'b0;
    logic [3:0] stray  = 4'b0;
    int         cnt_m [4];

    assign bus.act_done = done_m[0] | stray[0];
    assign bus.rw_done  = done_m[1] | stray[1];
    assign bus.pre_done = done_m[2] | stray[2];
    assign bus.ref_done = done_m[3] | stray[3];

    // Cycle number since reset release
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Start-pulse logger and generator responders, sampled mid-cycle
    always @(negedge clk) begin
        logic [3:0] st;
        st = {bus.ref_start, bus.pre_start, bus.rw_start, bus.act_start};
        if (!n_rst) begin
            ev_log = "";
        end else begin
            for (int i = 0; i < 4; i++)
                if (st[i]) ev_log = {ev_log, $sformatf("%s%0d ", tags[i], cyc)};
        end
        for (int i = 0; i < 4; i++) begin
            done_m[i] = 1'b0;
            if (!n_rst) begin
                cnt_m[i] = 0;
            end else begin
                if (cnt_m[i] > 0) begin
                    cnt_m[i] = cnt_m[i] - 1;
                    if (cnt_m[i] == 0) done_m[i] = 1'b1;
                end
                if (st[i]) cnt_m[i] = resp_dly;
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        stray         = 4'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = '1;
        stray         = 4'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        n_tests++;
        if ({bus.act_start, bus.rw_start, bus.pre_start, bus.ref_start} !== 4'b0) begin
            n_fail++; $display("FAIL reset_starts: got %b expected 0000",
                {bus.act_start, bus.rw_start, bus.pre_start, bus.ref_start});
        end
        n_tests++;
        if ({bus.bank, bus.row, bus.col, bus.is_write} !== 25'd0) begin
            n_fail++; $display("FAIL reset_fields: got %h expected 0",
                {bus.bank, bus.row, bus.col, bus.is_write});
        end
        bus.req_valid = 1'b0;
        n_rst = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b expected 1", bus.req_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_read();
        resp_dly = 1;
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = {2'd1, 13'h0123, 9'h045};
        wait_to(1);
        bus.req_valid = 1'b0;
        n_tests++;
        if ({bus.bank, bus.row, bus.col, bus.is_write} !== {2'd1, 13'h0123, 9'h045, 1'b0}) begin
            n_fail++; $display("FAIL read_fields: got bank=%h row=%h col=%h wr=%b expected bank=1 row=123 col=045 wr=0",
                bus.bank, bus.row, bus.col, bus.is_write);
        end
        wait_to(6);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL read_busy_prew: got %b expected 1", bus.busy);
        end
        wait_to(7);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL read_idle: got busy=%b ready=%b expected busy=0 ready=1",
                bus.busy, bus.req_ready);
        end
        wait_to(10);
        n_tests++;
        if (ev_log != "A1 W3 P5 ") begin
            n_fail++; $display("FAIL read_events: got '%s' expected 'A1 W3 P5 '", ev_log);
        end
        $display("[TB] test_single_read events '%s'", ev_log);
    endtask

    task automatic test_back_to_back();
        resp_dly = 1;
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = {2'd2, 13'h1AAA, 9'h1FF};
        wait_to(1);
        bus.req_write = 1'b0;
        bus.req_addr  = {2'd3, 13'h0F0F, 9'h0AA};
        for (int c = 1; c <= 6; c++) begin
            wait_to(c);
            n_tests++;
            if (bus.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL b2b_ready_c%0d: got %b expected 0", c, bus.req_ready);
            end
        end
        n_tests++;
        if (bus.is_write !== 1'b1 || bus.bank !== 2'd2 || bus.row !== 13'h1AAA) begin
            n_fail++; $display("FAIL b2b_first_fields: got wr=%b bank=%h row=%h expected wr=1 bank=2 row=1aaa",
                bus.is_write, bus.bank, bus.row);
        end
        wait_to(7);
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_idle: got %b expected 1", bus.req_ready);
        end
        wait_to(8);
        bus.req_valid = 1'b0;
        n_tests++;
        if ({bus.bank, bus.row, bus.col, bus.is_write} !== {2'd3, 13'h0F0F, 9'h0AA, 1'b0}) begin
            n_fail++; $display("FAIL b2b_second_fields: got bank=%h row=%h col=%h wr=%b expected bank=3 row=0f0f col=0aa wr=0",
                bus.bank, bus.row, bus.col, bus.is_write);
        end
        wait_to(15);
        n_tests++;
        if (ev_log != "A1 W3 P5 A8 W10 P12 ") begin
            n_fail++; $display("FAIL b2b_events: got '%s' expected 'A1 W3 P5 A8 W10 P12 '", ev_log);
        end
        $display("[TB] test_back_to_back events '%s'", ev_log);
    endtask

    task automatic test_refresh_idle();
        resp_dly = 1;
        do_reset();
        wait_to(19);
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ref_ready_c19: got %b expected 1", bus.req_ready);
        end
        wait_to(20);
        n_tests++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL ref_pending_c20: got ready=%b busy=%b expected ready=0 busy=0",
                bus.req_ready, bus.busy);
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = {2'd0, 13'h1FFF, 9'h000};
        wait_to(23);
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ref_ready_c23: got %b expected 1", bus.req_ready);
        end
        wait_to(24);
        bus.req_valid = 1'b0;
        n_tests++;
        if (bus.row !== 13'h1FFF || bus.is_write !== 1'b1) begin
            n_fail++; $display("FAIL ref_req_fields: got row=%h wr=%b expected row=1fff wr=1",
                bus.row, bus.is_write);
        end
        wait_to(45);
        n_tests++;
        if (ev_log != "R21 A24 W26 P28 R41 ") begin
            n_fail++; $display("FAIL ref_idle_events: got '%s' expected 'R21 A24 W26 P28 R41 '", ev_log);
        end
        $display("[TB] test_refresh_idle events '%s'", ev_log);
    endtask

    task automatic test_refresh_mid_write();
        resp_dly = 3;
        do_reset();
        wait_to(13);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = {2'd1, 13'h0777, 9'h101};
        wait_to(14);
        bus.req_write = 1'b0;
        bus.req_addr  = {2'd2, 13'h0002, 9'h003};
        wait_to(20);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL midw_c20: got busy=%b ready=%b expected busy=1 ready=0",
                bus.busy, bus.req_ready);
        end
        wait_to(26);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL midw_c26: got busy=%b ready=%b expected busy=0 ready=0",
                bus.busy, bus.req_ready);
        end
        wait_to(32);
        bus.req_valid = 1'b0;
        n_tests++;
        if (bus.bank !== 2'd2 || bus.is_write !== 1'b0) begin
            n_fail++; $display("FAIL midw_second_fields: got bank=%h wr=%b expected bank=2 wr=0",
                bus.bank, bus.is_write);
        end
        wait_to(34);
        n_tests++;
        if (ev_log != "A14 W18 P22 R27 A32 ") begin
            n_fail++; $display("FAIL midw_events: got '%s' expected 'A14 W18 P22 R27 A32 '", ev_log);
        end
        $display("[TB] test_refresh_mid_write events '%s'", ev_log);
    endtask

    task automatic test_reset_mid();
        resp_dly = 3;
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = {2'd3, 13'h1234, 9'h1AB};
        wait_to(1);
        bus.req_valid = 1'b0;
        wait_to(7);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.bank !== 2'd3) begin
            n_fail++; $display("FAIL rstmid_before: got busy=%b bank=%h expected busy=1 bank=3",
                bus.busy, bus.bank);
        end
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.req_ready, bus.act_start, bus.rw_start, bus.pre_start, bus.ref_start} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b expected 000000",
                {bus.busy, bus.req_ready, bus.act_start, bus.rw_start, bus.pre_start, bus.ref_start});
        end
        n_tests++;
        if ({bus.bank, bus.row, bus.col, bus.is_write} !== 25'd0) begin
            n_fail++; $display("FAIL rstmid_fields: got %h expected 0",
                {bus.bank, bus.row, bus.col, bus.is_write});
        end
        repeat (2) @(negedge clk);
        resp_dly = 1;
        n_rst = 1'b1;
        wait_to(5);
        stray = 4'b0110;
        wait_to(6);
        stray = 4'b0000;
        wait_to(8);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_stray_done: got busy=%b expected 0", bus.busy);
        end
        wait_to(23);
        n_tests++;
        if (ev_log != "R21 ") begin
            n_fail++; $display("FAIL rstmid_events: got '%s' expected 'R21 '", ev_log);
        end
        $display("[TB] test_reset_mid events '%s'", ev_log);
    endtask

`ifdef OPEN_ROW_EN
    task automatic test_open_row();
        resp_dly = 1;
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = {2'd1, 13'h0055, 9'h010};
        wait_to(1);
        bus.req_valid = 1'b0;
        wait_to(5);
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL open_ready_c5: got %b expected 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = {2'd1, 13'h0055, 9'h020};
        wait_to(6);
        bus.req_valid = 1'b0;
        n_tests++;
        if (bus.col !== 9'h020) begin
            n_fail++; $display("FAIL open_hit_col: got %h expected 020", bus.col);
        end
        wait_to(8);
        bus.req_valid = 1'b1;
        bus.req_addr  = {2'd1, 13'h0066, 9'h030};
        wait_to(9);
        bus.req_valid = 1'b0;
        wait_to(25);
        n_tests++;
        if (ev_log != "A1 W3 W6 P9 A11 W13 P21 R23 ") begin
            n_fail++; $display("FAIL open_events: got '%s' expected 'A1 W3 W6 P9 A11 W13 P21 R23 '", ev_log);
        end
        $display("[TB] test_open_row events '%s'", ev_log);
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        test_reset();
`ifdef OPEN_ROW_EN
        test_open_row();
`else
        test_single_read();
        test_back_to_back();
        test_refresh_idle();
        test_refresh_mid_write();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
